// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register map, vector layout.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package interrupt_controller_pkg;

    localparam int NUM_IRQ    = 8;
    localparam int IDX_W      = 3;
    localparam int VEC_STRIDE = 4;

    // Configuration register map
    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_BASE    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    // Handler address for line idx: one word-sized slot per line starting at base.
    function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [IDX_W-1:0] idx);
        return base + (32'(idx) * 32'(VEC_STRIDE));
    endfunction

endpackage

// File: rtl/interrupt_controller_prio_enc8.sv
// Fixed-priority encoder: index of the lowest set bit of an 8-bit request vector, plus valid.
// Latency: combinational.
// Backpressure: none; pure function of req.
//   req : request vector, bit 0 highest priority
//   idx : index of the winning bit (0 when vld is low)
//   vld : at least one request bit set
module prio_enc8
    import interrupt_controller_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               vld
);

    // Scan from the top down so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Eight-line edge-triggered interrupt controller with mask, vector base and IDLE/REQ/SVC handshake FSM.
// Latency: irq edge -> PENDING one cycle, PENDING & MASK -> INT one further cycle (registered).
// Backpressure: one request in flight; new edges accumulate in PENDING until the FSM returns to IDLE.
//   clk, rst_n            : clock, async active-low reset
//   irq[7:0]              : peripheral lines (bit 0 highest priority), synchronous to clk
//   INT, isr_addr         : registered request to CPU and handler address of the latched line
//   ack, eoi              : CPU acknowledge / end-of-interrupt pulses
//   cfg_we/addr/wdata     : register writes (MASK, BASE, PENDING W1C; STATUS read-only)
//   cfg_rdata             : combinational read of the selected register
module interrupt_controller
    import interrupt_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  irq,
    output logic        INT,
    input  logic        ack,
    input  logic        eoi,
    output logic [31:0] isr_addr,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata
);

    logic [NUM_IRQ-1:0] irq_q;
    logic               edge_en;
    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] mask_nxt;
    logic [29:0]        base_hi;
    logic [31:0]        base;
    logic [NUM_IRQ-1:0] w1c_clr;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] eligible;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    state_t             state;
    logic [IDX_W-1:0]   idx;

    logic wr_mask;
    logic wr_base;
    logic wr_pending;

    assign wr_mask    = cfg_we && (cfg_addr == ADDR_MASK);
    assign wr_base    = cfg_we && (cfg_addr == ADDR_BASE);
    assign wr_pending = cfg_we && (cfg_addr == ADDR_PENDING);

    assign base = {base_hi, 2'b00};

    // edge_en stays low for the first cycle after reset so a line already high
    // is loaded into irq_q before it can be mistaken for a rising edge.
    assign irq_rise = edge_en ? (irq & ~irq_q) : '0;

    assign w1c_clr = wr_pending ? cfg_wdata[NUM_IRQ-1:0] : '0;
    assign ack_clr = ((state == ST_REQ) && ack) ? (NUM_IRQ'(1) << idx) : '0;

    // Clears are applied first so a same-cycle edge always re-sets the bit.
    assign pending_nxt = (pending & ~w1c_clr & ~ack_clr) | irq_rise;
    assign mask_nxt    = wr_mask ? cfg_wdata[NUM_IRQ-1:0] : mask;
    assign eligible    = pending & mask;

    prio_enc8 u_prio (
        .req (eligible),
        .idx (win_idx),
        .vld (win_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q   <= '0;
            edge_en <= 1'b0;
            pending <= '0;
            mask    <= '0;
            base_hi <= '0;
        end else begin
            irq_q   <= irq;
            edge_en <= 1'b1;
            pending <= pending_nxt;
            mask    <= mask_nxt;
            if (wr_base) begin
                base_hi <= cfg_wdata[31:2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            INT      <= 1'b0;
            idx      <= '0;
            isr_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        idx      <= win_idx;
                        isr_addr <= vec_addr(base, win_idx);
                        INT      <= 1'b1;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack) begin
                        INT   <= 1'b0;
                        state <= ST_SVC;
                    end else if (!pending_nxt[idx] || !mask_nxt[idx]) begin
                        // Request withdrawn by W1C or masking: INT drops on this edge.
                        INT   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_SVC: begin
                    if (eoi) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    INT   <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_MASK:    cfg_rdata = {24'b0, mask};
            ADDR_BASE:    cfg_rdata = base;
            ADDR_PENDING: cfg_rdata = {24'b0, pending};
            ADDR_STATUS:  cfg_rdata = {24'b0, state, 3'b000, idx};
            default:      cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
// Latency: n/a.
// Backpressure: n/a.
module tb_interrupt_controller;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq;
    logic        INT;
    logic        ack;
    logic        eoi;
    logic [31:0] isr_addr;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;

    int total = 0;
    int bad   = 0;

    interrupt_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq       (irq),
        .INT       (INT),
        .ack       (ack),
        .eoi       (eoi),
        .isr_addr  (isr_addr),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        cfg_addr = a;
        #1;
        d = cfg_rdata;
        check(tag, d, exp);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq = '0; ack = 1'b0; eoi = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;

        // Reset state
        #3;
        check("rst_int", {31'b0, INT}, 32'h0);
        check("rst_isr", isr_addr, 32'h0);
        chk_reg("rst_mask", 2'd0, 32'h0);
        chk_reg("rst_base", 2'd1, 32'h0);
        chk_reg("rst_pend", 2'd2, 32'h0);
        chk_reg("rst_status", 2'd3, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single request on line 5
        cfg_write(2'd0, 32'hFF);
        cfg_write(2'd1, 32'h103);
        chk_reg("base_low_bits", 2'd1, 32'h100);
        chk_reg("mask_ff", 2'd0, 32'hFF);
        irq = 8'h20;
        tick();
        check("t1_int_early", {31'b0, INT}, 32'h0);
        chk_reg("t1_pend", 2'd2, 32'h20);
        irq = 8'h00;
        tick();
        check("t1_int", {31'b0, INT}, 32'h1);
        check("t1_isr", isr_addr, 32'h114);
        chk_reg("t1_status_req", 2'd3, 32'h45);
        pulse_ack();
        check("t1_int_ack", {31'b0, INT}, 32'h0);
        chk_reg("t1_pend_ack", 2'd2, 32'h0);
        chk_reg("t1_status_svc", 2'd3, 32'h85);
        cfg_write(2'd1, 32'h200);
        check("t1_isr_hold", isr_addr, 32'h114);
        cfg_write(2'd1, 32'h100);
        pulse_eoi();
        chk_reg("t1_status_idle", 2'd3, 32'h05);

        // Lines 3 and 6 together: 3 first, 6 after eoi
        irq = 8'h48;
        tick();
        irq = 8'h00;
        chk_reg("t2_pend", 2'd2, 32'h48);
        tick();
        check("t2_int", {31'b0, INT}, 32'h1);
        check("t2_isr3", isr_addr, 32'h10C);
        chk_reg("t2_status3", 2'd3, 32'h43);
        pulse_ack();
        chk_reg("t2_status_svc", 2'd3, 32'h83);
        chk_reg("t2_pend_left", 2'd2, 32'h40);
        pulse_ack();
        chk_reg("t2_ack_in_svc", 2'd3, 32'h83);
        chk_reg("t2_pend_keep", 2'd2, 32'h40);
        pulse_eoi();
        check("t2_int_gap", {31'b0, INT}, 32'h0);
        chk_reg("t2_status_gap", 2'd3, 32'h03);
        tick();
        check("t2_int6", {31'b0, INT}, 32'h1);
        check("t2_isr6", isr_addr, 32'h118);
        chk_reg("t2_status6", 2'd3, 32'h46);
        pulse_ack();
        pulse_eoi();
        chk_reg("t2_status_end", 2'd3, 32'h06);

        // Masked line stays pending; unmasking raises INT two edges after the write
        cfg_write(2'd0, 32'h00);
        irq = 8'h04;
        tick();
        irq = 8'h00;
        tick();
        check("t3_int_masked", {31'b0, INT}, 32'h0);
        chk_reg("t3_pend", 2'd2, 32'h04);
        tick();
        check("t3_int_masked2", {31'b0, INT}, 32'h0);
        cfg_write(2'd0, 32'h04);
        check("t3_int_wr", {31'b0, INT}, 32'h0);
        tick();
        check("t3_int", {31'b0, INT}, 32'h1);
        check("t3_isr", isr_addr, 32'h108);
        pulse_ack();
        pulse_eoi();

        // W1C of the requested line withdraws the request
        cfg_write(2'd0, 32'hFF);
        irq = 8'h02;
        tick();
        irq = 8'h00;
        tick();
        chk_reg("t4_status_req", 2'd3, 32'h41);
        cfg_write(2'd2, 32'h02);
        check("t4_int_drop", {31'b0, INT}, 32'h0);
        chk_reg("t4_status_idle", 2'd3, 32'h01);
        chk_reg("t4_pend", 2'd2, 32'h00);
        pulse_ack();
        chk_reg("t4_no_svc", 2'd3, 32'h01);

        // Same-cycle edge and W1C on line 4: edge wins
        cfg_write(2'd0, 32'h00);
        irq = 8'h10;
        tick();
        irq = 8'h00;
        tick();
        chk_reg("t5_pend_pre", 2'd2, 32'h10);
        irq = 8'h10;
        cfg_write(2'd2, 32'h10);
        irq = 8'h00;
        chk_reg("t5_edge_wins", 2'd2, 32'h10);
        cfg_write(2'd2, 32'h10);
        chk_reg("t5_w1c", 2'd2, 32'h00);
        cfg_write(2'd3, 32'hFFFFFFFF);
        chk_reg("t5_status_ro", 2'd3, 32'h01);
        chk_reg("t5_mask_kept", 2'd0, 32'h00);

        // Reset during SVC with irq[0] held high
        cfg_write(2'd0, 32'hFF);
        irq = 8'h01;
        tick();
        tick();
        check("t6_isr", isr_addr, 32'h100);
        pulse_ack();
        chk_reg("t6_status_svc", 2'd3, 32'h80);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_int", {31'b0, INT}, 32'h0);
        check("t6_rst_isr", isr_addr, 32'h0);
        chk_reg("t6_rst_mask", 2'd0, 32'h0);
        chk_reg("t6_rst_base", 2'd1, 32'h0);
        chk_reg("t6_rst_pend", 2'd2, 32'h0);
        chk_reg("t6_rst_status", 2'd3, 32'h0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk_reg("t6_no_edge_pend", 2'd2, 32'h0);
        cfg_write(2'd0, 32'hFF);
        tick();
        tick();
        check("t6_no_req_int", {31'b0, INT}, 32'h0);
        chk_reg("t6_no_req_pend", 2'd2, 32'h0);
        chk_reg("t6_status_idle", 2'd3, 32'h0);
        irq = 8'h00;
        tick();
        irq = 8'h01;
        tick();
        chk_reg("t6_new_pend", 2'd2, 32'h01);
        tick();
        check("t6_new_int", {31'b0, INT}, 32'h1);
        check("t6_new_isr", isr_addr, 32'h0);
        chk_reg("t6_new_status", 2'd3, 32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
